alu_arbiter: RTL and testbench

//  Shares the single 32-bit ALU between two requesters (r0, r1) via valid/ready handshakes.

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation runs IDLE -> EXEC -> RESP with the result returned by handshake.
module alu_arbiter #(
    parameter int WIDTH    = 32,
    parameter int OPW      = 3,
    parameter int CHECK_OP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_data1,
    input  logic [WIDTH-1:0] r0_data2,
    input  logic [OPW-1:0]   r0_ALUOp,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_ALUResult,
    output logic             r0_Zero,
    output logic             r0_err,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_data1,
    input  logic [WIDTH-1:0] r1_data2,
    input  logic [OPW-1:0]   r1_ALUOp,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_ALUResult,
    output logic             r1_Zero,
    output logic             r1_err,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [OPW-1:0]   alu_ALUOp,
    input  logic [WIDTH-1:0] alu_ALUResult,
    input  logic             alu_Zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nx;
    logic             last_grant;
    logic             grant;
    logic             take;
    logic             cur_p0;
    logic             ill_p0;
    logic [WIDTH-1:0] sel_data1, sel_data2;
    logic [OPW-1:0]   sel_op;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        if (CHECK_OP == 0) return 1'b1;
        return (op == OPW'(3'b000)) || (op == OPW'(3'b001)) || (op == OPW'(3'b010)) ||
               (op == OPW'(3'b110)) || (op == OPW'(3'b111));
    endfunction

    assign sel_data1 = grant ? r1_data1 : r0_data1;
    assign sel_data2 = grant ? r1_data2 : r0_data2;
    assign sel_op    = grant ? r1_ALUOp : r0_ALUOp;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Ready is only offered to a valid requester, so the loser of a tie sees ready=0
    always_comb begin
        state_nx     = state;
        grant        = 1'b0;
        take         = 1'b0;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                grant = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
                if (!reset) begin
                    r0_ready = r0_valid && !grant;
                    r1_ready = r1_valid && grant;
                end
                take = r0_ready || r1_ready;
                if (take) state_nx = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: begin
                r0_rsp_valid = !cur_p0;
                r1_rsp_valid = cur_p0;
                if (cur_p0 ? r1_rsp_ready : r0_rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            cur_p0     <= 1'b0;
            ill_p0     <= 1'b0;
        end else begin
            if (take) begin
                cur_p0 <= grant;
                ill_p0 <= !op_legal(sel_op);
            end
            if (state == RESP && state_nx == IDLE) last_grant <= cur_p0;
        end
    end

    // IDLE -> EXEC: legal operands are registered onto the ALU bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_data1 <= '0;
            alu_data2 <= '0;
            alu_ALUOp <= '0;
        end else if (take && op_legal(sel_op)) begin
            alu_data1 <= sel_data1;
            alu_data2 <= sel_data2;
            alu_ALUOp <= sel_op;
        end
    end

    // EXEC -> RESP: capture the ALU outputs for the granted requester only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r0_ALUResult <= '0;
            r0_Zero      <= 1'b0;
            r0_err       <= 1'b0;
            r1_ALUResult <= '0;
            r1_Zero      <= 1'b0;
            r1_err       <= 1'b0;
        end else if (state == EXEC) begin
            if (!cur_p0) begin
                r0_ALUResult <= ill_p0 ? '0 : alu_ALUResult;
                r0_Zero      <= ill_p0 ? 1'b0 : alu_Zero;
                r0_err       <= ill_p0;
            end else begin
                r1_ALUResult <= ill_p0 ? '0 : alu_ALUResult;
                r1_Zero      <= ill_p0 ? 1'b0 : alu_Zero;
                r1_err       <= ill_p0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter with a transaction-level reference model
// and a behavioural ALU attached to the arbiter's ALU port.
module tb_alu_arbiter;
    localparam int W  = 32;
    localparam int OW = 3;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          req_v   [2];
    logic [W-1:0]  req_a   [2];
    logic [W-1:0]  req_b   [2];
    logic [OW-1:0] req_op  [2];
    logic          rsp_rdy [2];

    logic r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
    logic [W-1:0] r0_ALUResult, r1_ALUResult;
    logic r0_Zero, r1_Zero, r0_err, r1_err;
    logic [W-1:0] alu_data1, alu_data2, alu_ALUResult;
    logic [OW-1:0] alu_ALUOp;
    logic alu_Zero, busy;

    logic [1:0]   rdy, rv, zr, er;
    logic [W-1:0] res [2];

    int n_chk, n_fail;
    logic [W-1:0]  m_a, m_b;
    logic [OW-1:0] m_op;
    int            m_last;

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OW-1:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return a ^ b;
        endcase
    endfunction

    function automatic bit legal(input logic [OW-1:0] op);
        return op inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
    endfunction

    assign alu_ALUResult = alu_fn(alu_data1, alu_data2, alu_ALUOp);
    assign alu_Zero      = (alu_ALUResult == '0);

    assign rdy    = {r1_ready, r0_ready};
    assign rv     = {r1_rsp_valid, r0_rsp_valid};
    assign zr     = {r1_Zero, r0_Zero};
    assign er     = {r1_err, r0_err};
    assign res[0] = r0_ALUResult;
    assign res[1] = r1_ALUResult;

    alu_arbiter #(.WIDTH(W), .OPW(OW), .CHECK_OP(1)) u_dut (
        .clk(clk), .reset(reset),
        .r0_valid(req_v[0]), .r0_ready(r0_ready), .r0_data1(req_a[0]), .r0_data2(req_b[0]),
        .r0_ALUOp(req_op[0]), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(rsp_rdy[0]),
        .r0_ALUResult(r0_ALUResult), .r0_Zero(r0_Zero), .r0_err(r0_err),
        .r1_valid(req_v[1]), .r1_ready(r1_ready), .r1_data1(req_a[1]), .r1_data2(req_b[1]),
        .r1_ALUOp(req_op[1]), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(rsp_rdy[1]),
        .r1_ALUResult(r1_ALUResult), .r1_Zero(r1_Zero), .r1_err(r1_err),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ALUOp(alu_ALUOp),
        .alu_ALUResult(alu_ALUResult), .alu_Zero(alu_Zero), .busy(busy)
    );

    // Second instance with opcode checking disabled
    logic n_v, n_rdy, n_rspv, n_zero, n_err, n1_rdy, n1_rspv, n1_zero, n1_err, n_alu_zero, n_busy;
    logic [W-1:0] n_a, n_b, n_res, n1_res, n_alu_d1, n_alu_d2, n_alu_res;
    logic [OW-1:0] n_op, n_alu_op;
    assign n_alu_res  = alu_fn(n_alu_d1, n_alu_d2, n_alu_op);
    assign n_alu_zero = (n_alu_res == '0);

    alu_arbiter #(.WIDTH(W), .OPW(OW), .CHECK_OP(0)) u_nc (
        .clk(clk), .reset(reset),
        .r0_valid(n_v), .r0_ready(n_rdy), .r0_data1(n_a), .r0_data2(n_b),
        .r0_ALUOp(n_op), .r0_rsp_valid(n_rspv), .r0_rsp_ready(1'b1),
        .r0_ALUResult(n_res), .r0_Zero(n_zero), .r0_err(n_err),
        .r1_valid(1'b0), .r1_ready(n1_rdy), .r1_data1('0), .r1_data2('0),
        .r1_ALUOp('0), .r1_rsp_valid(n1_rspv), .r1_rsp_ready(1'b1),
        .r1_ALUResult(n1_res), .r1_Zero(n1_zero), .r1_err(n1_err),
        .alu_data1(n_alu_d1), .alu_data2(n_alu_d2), .alu_ALUOp(n_alu_op),
        .alu_ALUResult(n_alu_res), .alu_Zero(n_alu_zero), .busy(n_busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [OW-1:0] op);
        req_v[i]  = 1'b1;
        req_a[i]  = a;
        req_b[i]  = b;
        req_op[i] = op;
    endtask

    // One complete operation: grant, EXEC, RESP (optionally held), completion
    task automatic serve(input int hold, input bit keep);
        int g, k;
        bit ill;
        logic [W-1:0] e_res;
        logic e_zero;
        #1;
        chk("idle_busy", W'(busy), W'(0));
        g = (req_v[0] && req_v[1]) ? ((m_last == 1) ? 0 : 1) : (req_v[0] ? 0 : 1);
        k = 0;
        while (rdy == 2'b00 && k < 4) begin
            @(negedge clk); #1;
            k++;
        end
        chk("ready_lat", W'(k), W'(0));
        if (rdy == 2'b00) return;
        chk("grant", W'(rdy), W'(1) << g);
        ill    = !legal(req_op[g]);
        e_res  = ill ? '0 : alu_fn(req_a[g], req_b[g], req_op[g]);
        e_zero = ill ? 1'b0 : (e_res == '0);
        if (!ill) begin
            m_a  = req_a[g];
            m_b  = req_b[g];
            m_op = req_op[g];
        end
        if (hold > 0) rsp_rdy[g] = 1'b0;
        @(negedge clk);
        req_v[g] = keep;
        #1;
        chk("exec_busy", W'(busy), W'(1));
        chk("exec_ready", W'(rdy), W'(0));
        chk("exec_rspv", W'(rv), W'(0));
        chk("alu_d1", alu_data1, m_a);
        chk("alu_d2", alu_data2, m_b);
        chk("alu_op", W'(alu_ALUOp), W'(m_op));
        @(negedge clk); #1;
        chk("rsp_valid", W'(rv), W'(1) << g);
        chk("rsp_ready_blk", W'(rdy), W'(0));
        chk("result", res[g], e_res);
        chk("zero", W'(zr[g]), W'(e_zero));
        chk("err", W'(er[g]), W'(ill));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk("hold_rspv", W'(rv), W'(1) << g);
            chk("hold_result", res[g], e_res);
            chk("hold_ready", W'(rdy), W'(0));
        end
        rsp_rdy[g] = 1'b1;
        @(negedge clk); #1;
        chk("done_rspv", W'(rv), W'(0));
        m_last = g;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        m_a = '0; m_b = '0; m_op = '0; m_last = 1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; req_a[i] = '0; req_b[i] = '0; req_op[i] = '0; rsp_rdy[i] = 1'b1;
        end
        n_v = 1'b0; n_a = '0; n_b = '0; n_op = '0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_ready", W'(rdy), W'(0));
        chk("rst_rspv", W'(rv), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_alu_d1", alu_data1, '0);
        chk("rst_result0", res[0], '0);
        @(negedge clk);
        reset = 1'b0;

        set_req(0, 32'd5, 32'd7, 3'b010);
        serve(0, 0);
        set_req(1, 32'hFFFF_0000, 32'h0000_FFFF, 3'b000);
        serve(0, 0);

        set_req(0, 32'd9, 32'd9, 3'b110);
        set_req(1, 32'd0, 32'd0, 3'b001);
        serve(0, 1);
        serve(0, 1);
        serve(0, 1);
        req_v[0] = 1'b0; req_v[1] = 1'b0;

        set_req(0, 32'd1, 32'd2, 3'b010);
        set_req(1, 32'h1234_5678, 32'h0F0F_0F0F, 3'b001);
        serve(10, 0);
        req_v[0] = 1'b0;

        set_req(1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b010);
        serve(0, 0);
        set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b111);
        serve(0, 0);
        set_req(1, 32'd11, 32'd22, 3'b011);
        serve(0, 0);

        set_req(0, 32'd3, 32'd4, 3'b010);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", W'(rdy), W'(0));
        chk("mid_rst_rspv", W'(rv), W'(0));
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_alu_d1", alu_data1, '0);
        chk("mid_rst_alu_op", W'(alu_ALUOp), W'(0));
        chk("mid_rst_result0", res[0], '0);
        chk("mid_rst_zero_err", W'({zr, er}), W'(0));
        m_a = '0; m_b = '0; m_op = '0; m_last = 1;
        @(negedge clk);
        reset = 1'b0;
        set_req(1, 32'd8, 32'd8, 3'b110);
        serve(0, 0);
        req_v[1] = 1'b0;

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 2; i++) begin
                req_v[i]  = 1'($urandom_range(0, 1));
                req_a[i]  = $urandom;
                req_b[i]  = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
                req_op[i] = OW'($urandom_range(0, 7));
            end
            if (!req_v[0] && !req_v[1]) req_v[$urandom_range(0, 1)] = 1'b1;
            serve($urandom_range(0, 2), 0);
            req_v[0] = 1'b0; req_v[1] = 1'b0;
        end

        n_a = 32'hF0F0_1234; n_b = 32'h0FF0_4321; n_op = 3'b011; n_v = 1'b1;
        #1;
        chk("nc_ready", W'(n_rdy), W'(1));
        @(negedge clk);
        n_v = 1'b0;
        #1;
        chk("nc_alu_op", W'(n_alu_op), W'(3'b011));
        @(negedge clk); #1;
        chk("nc_rspv", W'(n_rspv), W'(1));
        chk("nc_result", n_res, 32'hF0F0_1234 ^ 32'h0FF0_4321);
        chk("nc_err", W'(n_err), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
